// File: rtl/hand_bank_if.sv
// Deal handshake between the game FSM (master) and the hand bank (slave).
// The card code comes from dealcard but travels with the request it belongs to.
interface hand_bank_if #(
  parameter int HW = 1
);
  logic [3:0]    new_card;
  logic          deal_valid;
  logic [HW-1:0] deal_hand;
  logic          deal_ready;
  logic          deal_err;

  modport master (
    output new_card, deal_valid, deal_hand,
    input  deal_ready, deal_err
  );

  modport slave (
    input  new_card, deal_valid, deal_hand,
    output deal_ready, deal_err
  );
endinterface

// File: rtl/hand_bank.sv
// Baccarat hand storage: card slots, counts and registered mod-10 scores for
// NUM_HANDS hands, with a random-access card read port for the display.
module hand_bank #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  localparam int CW = $clog2(MAX_CARDS + 1)
) (
  input  logic                    slow_clock,
  input  logic                    resetb,
  hand_bank_if.slave              bus,
  input  logic                    clear,
  input  logic [HW-1:0]           rd_hand,
  input  logic [CW-1:0]           rd_slot,
  output logic [3:0]              rd_card,
  output logic [NUM_HANDS*4-1:0]  score,
  output logic [NUM_HANDS*CW-1:0] count,
  output logic [NUM_HANDS-1:0]    full,
  output logic [NUM_HANDS-1:0]    natural
);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    slot_reg  [NUM_HANDS][MAX_CARDS];
  logic [CW-1:0] count_reg [NUM_HANDS];
  logic [3:0]    score_reg [NUM_HANDS];
  logic [HW-1:0] hand_lat_reg;
  logic [3:0]    face_lat_reg;
  logic          deal_err_reg, deal_err_next;

  logic          hand_ok, card_ok, sel_full, accept;
  logic [3:0]    face;
  logic [4:0]    score_sum;
  logic [3:0]    score_upd;

  always_comb begin
    hand_ok  = ({1'b0, bus.deal_hand} < (HW + 1)'(NUM_HANDS));
    card_ok  = (bus.new_card >= 4'd1) && (bus.new_card <= 4'd13);
    sel_full = 1'b0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (bus.deal_hand == HW'(h)) sel_full = full[h];
    end
    face   = (bus.new_card <= 4'd9) ? bus.new_card : 4'd0;
    accept = (state_reg == IDLE) && bus.deal_valid && hand_ok && card_ok &&
             !sel_full && !clear;
  end

  // Both operands are 0..9, so a single conditional subtract keeps it mod 10.
  always_comb begin
    score_sum = {1'b0, score_reg[hand_lat_reg]} + {1'b0, face_lat_reg};
    score_upd = (score_sum >= 5'd10) ? 4'(score_sum - 5'd10) : score_sum[3:0];
  end

  always_comb begin
    state_next    = state_reg;
    deal_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = UPDATE;
        deal_err_next = bus.deal_valid && !accept && !clear;
      end
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_reg    <= IDLE;
      deal_err_reg <= 1'b0;
      hand_lat_reg <= '0;
      face_lat_reg <= '0;
    end else begin
      state_reg    <= state_next;
      deal_err_reg <= deal_err_next;
      if (accept) begin
        hand_lat_reg <= bus.deal_hand;
        face_lat_reg <= face;
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        count_reg[h] <= '0;
        score_reg[h] <= '0;
        for (int s = 0; s < MAX_CARDS; s++) slot_reg[h][s] <= '0;
      end
    end else if (clear) begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        count_reg[h] <= '0;
        score_reg[h] <= '0;
        for (int s = 0; s < MAX_CARDS; s++) slot_reg[h][s] <= '0;
      end
    end else begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        if (accept && bus.deal_hand == HW'(h)) begin
          count_reg[h] <= count_reg[h] + CW'(1);
          for (int s = 0; s < MAX_CARDS; s++) begin
            if (count_reg[h] == CW'(s)) slot_reg[h][s] <= bus.new_card;
          end
        end
        if (state_reg == UPDATE && hand_lat_reg == HW'(h)) score_reg[h] <= score_upd;
      end
    end
  end

  // Slots beyond the count read as 0 even though storage is also zeroed on clear.
  always_comb begin
    rd_card = 4'd0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      for (int s = 0; s < MAX_CARDS; s++) begin
        if (rd_hand == HW'(h) && rd_slot == CW'(s) && CW'(s) < count_reg[h])
          rd_card = slot_reg[h][s];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HANDS; gi++) begin : g_hand
      assign score[4*gi +: 4]   = score_reg[gi];
      assign count[CW*gi +: CW] = count_reg[gi];
      assign full[gi]           = (count_reg[gi] == CW'(MAX_CARDS));
      assign natural[gi]        = (count_reg[gi] == CW'(2)) && (score_reg[gi] >= 4'd8);
    end
  endgenerate

  assign bus.deal_ready = (state_reg == IDLE);
  assign bus.deal_err   = deal_err_reg;

endmodule

// File: tb/tb_hand_bank.sv
// Randomised and directed bench for hand_bank against a card-list model:
// each hand is a list of dealt cards and its score is recomputed from the list.
module tb_hand_bank;
  localparam int NH = 3;
  localparam int MC = 3;
  localparam int HW = 2;
  localparam int CW = 2;

  logic            slow_clock = 1'b0;
  logic            resetb = 1'b0;
  logic            clear = 1'b0;
  logic [HW-1:0]   rd_hand = '0;
  logic [CW-1:0]   rd_slot = '0;
  logic [3:0]      rd_card;
  logic [NH*4-1:0] score;
  logic [NH*CW-1:0] count;
  logic [NH-1:0]   full;
  logic [NH-1:0]   natural;

  hand_bank_if #(.HW(HW)) bus();

  hand_bank #(.NUM_HANDS(NH), .MAX_CARDS(MC)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus.slave),
    .clear      (clear),
    .rd_hand    (rd_hand),
    .rd_slot    (rd_slot),
    .rd_card    (rd_card),
    .score      (score),
    .count      (count),
    .full       (full),
    .natural    (natural)
  );

  always #5 slow_clock = ~slow_clock;

  int n_cmp = 0;
  int n_bad = 0;

  int cards [NH][MC];
  int cnt   [NH];
  bit pending;
  int pend_hand;
  bit exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int face_of(input int c);
    return (c <= 9) ? c : 0;
  endfunction

  // A just-accepted card is counted but not yet added into the score.
  function automatic int exp_score(input int h);
    int n, sum;
    n = cnt[h];
    if (pending && pend_hand == h) n--;
    sum = 0;
    for (int k = 0; k < n; k++) sum += face_of(cards[h][k]);
    return sum % 10;
  endfunction

  task automatic model_clear();
    for (int h = 0; h < NH; h++) begin
      cnt[h] = 0;
      for (int s = 0; s < MC; s++) cards[h][s] = 0;
    end
    pending = 0;
    exp_err = 0;
  endtask

  task automatic model_edge();
    int h, c;
    h = int'(bus.deal_hand);
    c = int'(bus.new_card);
    if (clear) begin
      model_clear();
      return;
    end
    exp_err = 0;
    if (pending) begin
      pending = 0;
    end else if (bus.deal_valid) begin
      if (h < NH && cnt[h] < MC && c >= 1 && c <= 13) begin
        cards[h][cnt[h]] = c;
        cnt[h]++;
        pending   = 1;
        pend_hand = h;
      end else begin
        exp_err = 1;
      end
    end
  endtask

  task automatic check_all();
    int es, rh, rs, er;
    check("deal_ready", 32'(bus.deal_ready), 32'(!pending));
    check("deal_err", 32'(bus.deal_err), 32'(exp_err));
    for (int h = 0; h < NH; h++) begin
      es = exp_score(h);
      check($sformatf("score[%0d]", h), 32'(score[4*h +: 4]), 32'(es));
      check($sformatf("count[%0d]", h), 32'(count[CW*h +: CW]), 32'(cnt[h]));
      check($sformatf("full[%0d]", h), 32'(full[h]), 32'(cnt[h] == MC));
      check($sformatf("natural[%0d]", h), 32'(natural[h]), 32'(cnt[h] == 2 && es >= 8));
    end
    rh = $urandom_range(0, 3);
    rs = $urandom_range(0, 3);
    rd_hand = HW'(rh);
    rd_slot = CW'(rs);
    #1;
    er = (rh < NH && rs < cnt[rh < NH ? rh : 0]) ? cards[rh][rs] : 0;
    check($sformatf("rd_card(%0d,%0d)", rh, rs), 32'(rd_card), 32'(er));
  endtask

  task automatic drive(input bit dv, input int dh, input int nc, input bit clr);
    bus.deal_valid = dv;
    bus.deal_hand  = HW'(dh);
    bus.new_card   = 4'(nc);
    clear          = clr;
  endtask

  task automatic step();
    model_edge();
    @(posedge slow_clock);
    #1;
    check_all();
  endtask

  task automatic deal(input int h, input int c);
    drive(1, h, c, 0);
    step();
    drive(0, 0, 0, 0);
    step();
  endtask

  task automatic async_reset();
    #2;
    resetb = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0);
    model_clear();
    #2;
    check_all();
    @(negedge slow_clock);
    resetb = 1'b1;
    step();

    deal(0, 9);
    deal(0, 13);
    deal(1, 7);
    deal(1, 8);
    deal(1, 5);
    deal(1, 2);

    drive(0, 0, 0, 1);
    step();
    drive(1, 0, 4, 0);
    repeat (4) step();
    drive(0, 0, 0, 0);
    step();

    deal(2, 0);
    deal(2, 14);
    deal(3, 5);

    drive(1, 2, 6, 0);
    step();
    drive(1, 1, 3, 1);
    step();
    drive(0, 0, 0, 0);
    step();

    deal(0, 3);
    deal(1, 4);
    async_reset();
    step();

    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, $urandom_range(0, 3), $urandom_range(0, 15),
            ($urandom % 32) == 0);
      step();
      if (($urandom % 100) == 0) async_reset();
    end

    drive(0, 0, 0, 0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
